// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling engine between the split I-/D-caches and main memory.
// Arbitrates between pending misses (D first), streams one 8-word block from a pipelined,
// in-order memory into the selected cache's data array, then writes the tag.
// Optional feature macro: FILL_CRITICAL_WORD_FIRST_EN (start the fill at the missing word).
module cache_fill_fsm #(
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_miss_i,
    input  logic [ADDR_W-1:0] i_miss_addr_i,
    input  logic              d_miss_i,
    input  logic [ADDR_W-1:0] d_miss_addr_i,
    output logic              mem_enable_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_data_valid_i,
    input  logic [15:0]       mem_data_in_i,
    output logic              fill_sel_o,
    output logic              data_wen_o,
    output logic [2:0]        data_word_o,
    output logic [15:0]       data_out_o,
    output logic              tag_wen_o,
    output logic              fill_busy_o,
    output logic              fill_done_o
);

    localparam int unsigned BaseW = ADDR_W - 4;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e           state_q, state_d;
    logic [BaseW-1:0] base_q, base_d;
    logic [3:0]       issue_cnt_q, issue_cnt_d;
    logic [2:0]       recv_cnt_q, recv_cnt_d;
    logic             fill_sel_q, fill_sel_d;
    logic [2:0]       start_q;
    logic [2:0]       issue_off;
    logic [2:0]       recv_off;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    logic [2:0] start_d;
    // Byte bit 0 never selects a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_miss_addr_i[0], d_miss_addr_i[0]};
`else
    // Fills always begin at word 0; the low miss-address bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_miss_addr_i[3:0], d_miss_addr_i[3:0]};
    assign start_q = 3'd0;
`endif

    // Word offsets wrap modulo the block size through 3-bit truncation.
    assign issue_off = start_q + issue_cnt_q[2:0];
    assign recv_off  = start_q + recv_cnt_q;

    // State, latched block base and progress counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            fill_sel_q  <= 1'b0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            start_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            fill_sel_q  <= fill_sel_d;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            start_q     <= start_d;
`endif
        end
    end

    // Next-state logic and combinational outputs; issue and return sides advance independently.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        fill_sel_d   = fill_sel_q;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        start_d      = start_q;
`endif
        mem_enable_o = 1'b0;
        mem_addr_o   = '0;
        fill_sel_o   = 1'b0;
        data_wen_o   = 1'b0;
        data_word_o  = '0;
        data_out_o   = '0;
        tag_wen_o    = 1'b0;
        fill_busy_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
                // D miss wins: it belongs to the older instruction in the pipeline.
                if (d_miss_i) begin
                    base_d     = d_miss_addr_i[ADDR_W-1:4];
                    fill_sel_d = 1'b1;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                    start_d    = d_miss_addr_i[3:1];
`endif
                    state_d    = StFill;
                end else if (i_miss_i) begin
                    base_d     = i_miss_addr_i[ADDR_W-1:4];
                    fill_sel_d = 1'b0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                    start_d    = i_miss_addr_i[3:1];
`endif
                    state_d    = StFill;
                end
            end
            StFill: begin
                fill_busy_o = 1'b1;
                fill_sel_o  = fill_sel_q;
                if (issue_cnt_q < 4'(BLOCK_WORDS)) begin
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {base_q, issue_off, 1'b0};
                    issue_cnt_d  = issue_cnt_q + 4'd1;
                end
                if (mem_data_valid_i) begin
                    data_wen_o  = 1'b1;
                    data_word_o = recv_off;
                    data_out_o  = mem_data_in_i;
                    recv_cnt_d  = recv_cnt_q + 3'd1;
                    // Tag goes in alongside the final data word.
                    if (recv_cnt_q == 3'(BLOCK_WORDS - 1)) begin
                        tag_wen_o   = 1'b1;
                        state_d     = StIdle;
                        issue_cnt_d = '0;
                        recv_cnt_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fill_done_o = tag_wen_o;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench for cache_fill_fsm; memory returns driven cycle by cycle.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        fill_sel, data_wen, tag_wen, fill_busy, fill_done;
    logic [2:0]  data_word;
    logic [15:0] data_out;

    int tests = 0;
    int fails = 0;
    int ret_cyc[8];

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .i_miss_i         (i_miss),
        .i_miss_addr_i    (i_miss_addr),
        .d_miss_i         (d_miss),
        .d_miss_addr_i    (d_miss_addr),
        .mem_enable_o     (mem_enable),
        .mem_addr_o       (mem_addr),
        .mem_data_valid_i (mem_data_valid),
        .mem_data_in_i    (mem_data_in),
        .fill_sel_o       (fill_sel),
        .data_wen_o       (data_wen),
        .data_word_o      (data_word),
        .data_out_o       (data_out),
        .tag_wen_o        (tag_wen),
        .fill_busy_o      (fill_busy),
        .fill_done_o      (fill_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_men"}, {15'd0, mem_enable}, 16'd0);
        chk({tag, "_maddr"}, mem_addr, 16'd0);
        chk({tag, "_sel"}, {15'd0, fill_sel}, 16'd0);
        chk({tag, "_dwen"}, {15'd0, data_wen}, 16'd0);
        chk({tag, "_dword"}, {13'd0, data_word}, 16'd0);
        chk({tag, "_dout"}, data_out, 16'd0);
        chk({tag, "_tag"}, {15'd0, tag_wen}, 16'd0);
        chk({tag, "_busy"}, {15'd0, fill_busy}, 16'd0);
        chk({tag, "_done"}, {15'd0, fill_done}, 16'd0);
    endtask

    task automatic set_fixed_latency(input int lat);
        for (int i = 0; i < 8; i++) ret_cyc[i] = i + 1 + lat;
    endtask

    // Entered in an IDLE cycle with the miss already driven; leaves in the IDLE cycle after tag_wen.
    task automatic run_fill(input string tag, input logic [15:0] miss_addr, input logic sel);
        logic [15:0] base;
        logic [2:0]  s;
        logic [2:0]  off;
        logic [15:0] dv;
        int          nret;
        base = miss_addr & 16'hFFF0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        s = miss_addr[3:1];
`else
        s = 3'd0;
`endif
        nret = 0;
        #1;
        chk({tag, "_pre_busy"}, {15'd0, fill_busy}, 16'd0);
        tick();
        for (int t = 1; t <= ret_cyc[7]; t++) begin
            mem_data_valid = (nret < 8) && (ret_cyc[nret] == t);
            dv = 16'h3C00 + 16'(t * 37);
            mem_data_in = dv;
            #1;
            chk({tag, "_busy"}, {15'd0, fill_busy}, 16'd1);
            chk({tag, "_sel"}, {15'd0, fill_sel}, {15'd0, sel});
            if (t <= 8) begin
                off = 3'(int'(s) + t - 1);
                chk({tag, "_men"}, {15'd0, mem_enable}, 16'd1);
                chk({tag, "_maddr"}, mem_addr, base | {12'd0, off, 1'b0});
            end else begin
                chk({tag, "_men_off"}, {15'd0, mem_enable}, 16'd0);
            end
            chk({tag, "_dwen"}, {15'd0, data_wen}, {15'd0, mem_data_valid});
            if (mem_data_valid) begin
                off = 3'(int'(s) + nret);
                chk({tag, "_dword"}, {13'd0, data_word}, {13'd0, off});
                chk({tag, "_dout"}, data_out, dv);
                chk({tag, "_tag"}, {15'd0, tag_wen}, (nret == 7) ? 16'd1 : 16'd0);
                chk({tag, "_done"}, {15'd0, fill_done}, (nret == 7) ? 16'd1 : 16'd0);
                nret++;
            end else begin
                chk({tag, "_tag_idle"}, {15'd0, tag_wen}, 16'd0);
            end
            if (nret == 8) begin
                if (sel) d_miss = 1'b0;
                else i_miss = 1'b0;
            end
            tick();
        end
        mem_data_valid = 1'b0;
        #1;
        chk({tag, "_post_busy"}, {15'd0, fill_busy}, 16'd0);
        chk({tag, "_post_dwen"}, {15'd0, data_wen}, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_miss = 1'b0;
        d_miss = 1'b0;
        i_miss_addr = '0;
        d_miss_addr = '0;
        mem_data_valid = 1'b0;
        mem_data_in = '0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // D miss, latency 4: tag_wen 12 cycles after the miss edge.
        set_fixed_latency(4);
        d_miss = 1'b1;
        d_miss_addr = 16'h1236;
        run_fill("dmiss", 16'h1236, 1'b1);

        // Simultaneous misses: D first, then I from the following IDLE cycle.
        set_fixed_latency(2);
        i_miss = 1'b1;
        i_miss_addr = 16'h0040;
        d_miss = 1'b1;
        d_miss_addr = 16'h2000;
        run_fill("both_d", 16'h2000, 1'b1);
        run_fill("both_i", 16'h0040, 1'b0);

        // I miss at 0x1236: word 3 first when critical-word-first is built in.
        set_fixed_latency(3);
        i_miss = 1'b1;
        i_miss_addr = 16'h1236;
        run_fill("imiss", 16'h1236, 1'b0);

        // Reset after three returned words.
        d_miss = 1'b1;
        d_miss_addr = 16'h4A08;
        tick();
        for (int t = 1; t <= 7; t++) begin
            mem_data_valid = (t >= 5);
            mem_data_in = 16'h7700 + 16'(t);
            #1;
            chk("rstmid_men", {15'd0, mem_enable}, 16'd1);
            chk("rstmid_dwen", {15'd0, data_wen}, {15'd0, mem_data_valid});
            tick();
        end
        d_miss = 1'b0;
        mem_data_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk_all_zero("rstmid_async");
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            mem_data_valid = 1'b1;
            #1;
            chk("rstlate_dwen", {15'd0, data_wen}, 16'd0);
            chk("rstlate_tag", {15'd0, tag_wen}, 16'd0);
            chk("rstlate_busy", {15'd0, fill_busy}, 16'd0);
            tick();
        end
        mem_data_valid = 1'b0;
        set_fixed_latency(4);
        d_miss = 1'b1;
        d_miss_addr = 16'h4A08;
        run_fill("refill", 16'h4A08, 1'b1);

        // Returns while IDLE with no miss are ignored.
        for (int t = 0; t < 3; t++) begin
            mem_data_valid = 1'b1;
            mem_data_in = 16'hBEEF;
            #1;
            chk("idlevld_dwen", {15'd0, data_wen}, 16'd0);
            chk("idlevld_tag", {15'd0, tag_wen}, 16'd0);
            chk("idlevld_busy", {15'd0, fill_busy}, 16'd0);
            tick();
            mem_data_valid = 1'b0;
            tick();
        end

        // Variable latency, returns 1-3 cycles apart.
        ret_cyc[0] = 3;  ret_cyc[1] = 5;  ret_cyc[2] = 8;  ret_cyc[3] = 9;
        ret_cyc[4] = 11; ret_cyc[5] = 14; ret_cyc[6] = 15; ret_cyc[7] = 18;
        i_miss = 1'b1;
        i_miss_addr = 16'h0A5C;
        run_fill("varlat", 16'h0A5C, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
